// File: rtl/impulse_train_generator_if.sv
// Command channel for the impulse train generator.
// Producer drives H/L/R with active-low dav_, consumer returns rfd.
interface impulse_train_generator_if #(
  parameter int W_LEN = 8,
  parameter int W_REP = 4
);
  logic [W_LEN-1:0] high_len;
  logic [W_LEN-1:0] low_len;
  logic [W_REP-1:0] rep;
  logic             dav_;
  logic             rfd;

  modport master (
    output high_len,
    output low_len,
    output rep,
    output dav_,
    input  rfd
  );

  modport slave (
    input  high_len,
    input  low_len,
    input  rep,
    input  dav_,
    output rfd
  );
endinterface

// File: rtl/impulse_train_generator.sv
// Impulse train generator: R impulses, H clocks high,
// separated by L clocks low, one command per /dav-rfd handshake.
module impulse_train_generator #(
  parameter int W_LEN = 8,
  parameter int W_REP = 4
) (
  input  logic                 clock,
  input  logic                 reset_,
  impulse_train_generator_if.slave cmd,
  output logic                 out,
  output logic                 busy,
  output logic [W_REP-1:0]     pulses_left
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    WAIT_DAV
  } state_t;

  state_t           state;
  logic [W_LEN-1:0] h_q;
  logic [W_LEN-1:0] l_q;
  logic [W_LEN-1:0] cnt;
  logic             rfd_q;

  localparam logic [W_LEN-1:0] LEN_ONE = W_LEN'(1);
  localparam logic [W_REP-1:0] REP_ONE = W_REP'(1);

  assign cmd.rfd = rfd_q;

  // Handshake, phase counting and registered outputs.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      h_q         <= '0;
      l_q         <= '0;
      cnt         <= '0;
      rfd_q       <= 1'b1;
      out         <= 1'b0;
      busy        <= 1'b0;
      pulses_left <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!cmd.dav_) begin
            h_q   <= cmd.high_len;
            l_q   <= cmd.low_len;
            rfd_q <= 1'b0;
            if (cmd.high_len == '0 || cmd.rep == '0) begin
              pulses_left <= '0;
              state       <= WAIT_DAV;
            end else begin
              out         <= 1'b1;
              busy        <= 1'b1;
              pulses_left <= cmd.rep;
              cnt         <= cmd.high_len;
              state       <= HIGH;
            end
          end
        end
        HIGH: begin
          if (cnt == LEN_ONE) begin
            pulses_left <= pulses_left - REP_ONE;
            if (pulses_left == REP_ONE) begin
              out   <= 1'b0;
              busy  <= 1'b0;
              state <= WAIT_DAV;
            end else if (l_q != '0) begin
              out   <= 1'b0;
              cnt   <= l_q;
              state <= LOW;
            end else begin
              cnt <= h_q;
            end
          end else begin
            cnt <= cnt - LEN_ONE;
          end
        end
        LOW: begin
          if (cnt == LEN_ONE) begin
            out   <= 1'b1;
            cnt   <= h_q;
            state <= HIGH;
          end else begin
            cnt <= cnt - LEN_ONE;
          end
        end
        WAIT_DAV: begin
          if (cmd.dav_) begin
            rfd_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_impulse_train_generator.sv
// Bench for impulse_train_generator: directed and random trains
// against an arithmetic model of the expected waveform.
module tb_impulse_train_generator;

  localparam int W_LEN = 8;
  localparam int W_REP = 4;

  logic             clock;
  logic             reset_;
  logic             out;
  logic             busy;
  logic [W_REP-1:0] pulses_left;

  int checks;
  int failures;

  impulse_train_generator_if #(
    .W_LEN(W_LEN),
    .W_REP(W_REP)
  ) cmd_if ();

  impulse_train_generator #(
    .W_LEN(W_LEN),
    .W_REP(W_REP)
  ) dut (
    .clock      (clock),
    .reset_     (reset_),
    .cmd        (cmd_if),
    .out        (out),
    .busy       (busy),
    .pulses_left(pulses_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic scramble();
    cmd_if.high_len = W_LEN'($urandom);
    cmd_if.low_len  = W_LEN'($urandom);
    cmd_if.rep      = W_REP'($urandom);
  endtask

  // One command; abort_at < 0 runs to completion, otherwise
  // reset_ is pulled low just after sample abort_at.
  task automatic run_train(
    input int h,
    input int l,
    input int r,
    input int hold,
    input int abort_at
  );
    int len;
    int last;
    int per;
    int done;
    bit eo;
    bit eb;
    bit ef;
    int ep;
    @(negedge clock);
    cmd_if.high_len = W_LEN'(h);
    cmd_if.low_len  = W_LEN'(l);
    cmd_if.rep      = W_REP'(r);
    cmd_if.dav_     = 1'b0;
    len  = (h == 0 || r == 0) ? 0 : r * h + (r - 1) * l;
    last = (len + 1 > hold) ? len + 1 : hold;
    per  = h + l;
    for (int k = 0; k <= last; k++) begin
      @(posedge clock);
      #1;
      if (k == abort_at) begin
        #1 reset_ = 1'b0;
        #1;
        check("abort_out", 32'(out), 32'd0);
        check("abort_rfd", 32'(cmd_if.rfd), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_left", 32'(pulses_left), 32'd0);
        @(negedge clock);
        reset_      = 1'b1;
        cmd_if.dav_ = 1'b1;
        return;
      end
      if (k < len) begin
        eo = (k % per) < h;
        eb = 1'b1;
        done = 0;
        for (int j = 0; j < r; j++)
          if (j * per + h <= k) done++;
        ep = r - done;
      end else begin
        eo = 1'b0;
        eb = 1'b0;
        ep = 0;
      end
      ef = (k >= len + 1) && (k >= hold);
      check("out", 32'(out), 32'(eo));
      check("busy", 32'(busy), 32'(eb));
      check("pulses_left", 32'(pulses_left), 32'(ep));
      check("rfd", 32'(cmd_if.rfd), 32'(ef));
      @(negedge clock);
      if (k + 1 >= hold) cmd_if.dav_ = 1'b1;
      scramble();
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_      = 1'b0;
    cmd_if.dav_ = 1'b1;
    scramble();
    repeat (3) @(posedge clock);
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rfd", 32'(cmd_if.rfd), 32'd1);
    check("rst_left", 32'(pulses_left), 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);

    run_train(3, 2, 2, 1, -1);
    run_train(1, 0, 4, 1, -1);
    run_train(0, 7, 5, 1, -1);
    run_train(5, 3, 0, 3, -1);
    run_train(2, 1, 3, 20, -1);
    run_train(4, 4, 3, 1, 9);
    run_train(2, 2, 2, 1, -1);
    run_train(255, 255, 15, 2, -1);

    for (int t = 0; t < 12; t++) begin
      run_train(int'($urandom_range(0, 6)),
                int'($urandom_range(0, 4)),
                int'($urandom_range(0, 5)),
                int'($urandom_range(1, 30)),
                -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
